// File: rtl/sig_dump_pkg.sv
// ---------------------------------------------------------------------------
// sig_dump_pkg
//   Shared definitions for the signature-dump mailbox: register word offsets
//   on the data bus and the dump FSM state encoding.
// ---------------------------------------------------------------------------
package sig_dump_pkg;

  localparam logic [1:0] REG_BEGIN  = 2'd0;
  localparam logic [1:0] REG_END    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RD    = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } sig_state_e;

endpackage

// File: rtl/sig_dump_ctrl.sv
// ---------------------------------------------------------------------------
// sig_dump_ctrl
//   Memory-mapped signature mailbox. Software writes BEGIN/END byte addresses
//   and then a CTRL start; the block reads RAM[BEGIN..END) one word at a time
//   through its own read port and streams each word on a valid/ready port,
//   then raises a sticky done.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   bus_wr/bus_rd            register write / read strobes
//   bus_addr                 word offset: 0 BEGIN, 1 END, 2 CTRL, 3 STATUS
//   bus_wdata / bus_rdata    write data / read data (valid the cycle after bus_rd)
//   mem_rd/mem_addr          RAM read request and word address
//   mem_rdata                RAM data, valid exactly one cycle after mem_rd
//   sig_valid/sig_data/
//   sig_last/sig_ready       signature word stream
//   busy, done               dump in progress / dump complete (sticky)
//   dbg_state                current FSM state (sig_state_e encoding)
//
// Stream handshake: a word transfers on a rising clk edge where sig_valid and
//   sig_ready are both 1. sig_valid is a pure function of the registered
//   state, so it never depends combinationally on sig_ready; once raised it
//   stays high with sig_data/sig_last stable until that transfer happens.
// ---------------------------------------------------------------------------
module sig_dump_ctrl
  import sig_dump_pkg::*;
#(
  parameter int RAM_AW = 22,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [1:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              mem_rd,
  output logic [RAM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              sig_valid,
  output logic [31:0]       sig_data,
  output logic              sig_last,
  input  logic              sig_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  sig_state_e        state_q, state_d;
  logic [31:0]       begin_q, end_q;
  logic [31:0]       ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       sig_data_q;
  logic [31:0]       rdata_q;

  logic              busy_w;
  logic              start_req;
  logic              last_w;
  logic              handshake;
  logic [31:0]       status_w;
  logic              unused_ok;

  // Bit 1 of the write data has no meaning in any register.
  assign unused_ok = bus_wdata[1];

  assign busy_w    = (state_q == START) || (state_q == RD) ||
                     (state_q == WAIT)  || (state_q == SEND);
  assign start_req = bus_wr && (bus_addr == REG_CTRL) && bus_wdata[0];
  assign handshake = (state_q == SEND) && sig_ready;

  // Compare in 33 bits so ptr+4 cannot wrap past END near the top of memory.
  assign last_w = ({1'b0, ptr_q} + 33'd4) >= {1'b0, end_q};

  always_comb begin
    status_w        = '0;
    status_w[31:16] = 16'(count_q);
    status_w[1]     = (state_q == DONE);
    status_w[0]     = busy_w;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_req) state_d = START;
      START: state_d = (begin_q >= end_q) ? DONE : RD;
      RD:    state_d = WAIT;
      WAIT:  state_d = SEND;
      SEND:  if (sig_ready) state_d = last_w ? DONE : RD;
      DONE:  if (start_req) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_rd    = 1'b0;
    mem_addr  = '0;
    sig_valid = 1'b0;
    sig_last  = 1'b0;
    busy      = busy_w;
    done      = (state_q == DONE);
    dbg_state = state_q;
    case (state_q)
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = ptr_q[RAM_AW+1:2];
      end
      SEND: begin
        sig_valid = 1'b1;
        sig_last  = last_w;
      end
      default: ;
    endcase
  end

  assign sig_data  = sig_data_q;
  assign bus_rdata = rdata_q;

  // ---------------- Register file and datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      begin_q    <= '0;
      end_q      <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      sig_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      // Address registers are frozen for the whole dump.
      if (bus_wr && !busy_w) begin
        if (bus_addr == REG_BEGIN) begin_q <= {bus_wdata[31:2], 2'b00};
        if (bus_addr == REG_END)   end_q   <= {bus_wdata[31:2], 2'b00};
      end

      if (bus_rd) begin
        case (bus_addr)
          REG_BEGIN:  rdata_q <= begin_q;
          REG_END:    rdata_q <= end_q;
          REG_STATUS: rdata_q <= status_w;
          default:    rdata_q <= '0;
        endcase
      end

      case (state_q)
        START: begin
          ptr_q   <= begin_q;
          count_q <= '0;
        end
        WAIT: sig_data_q <= mem_rdata;
        default: ;
      endcase

      if (handshake) begin
        ptr_q   <= ptr_q + 32'd4;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sig_dump_ctrl.sv
module tb_sig_dump_ctrl;

  localparam int RAM_AW = 22;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              bus_wr;
  logic              bus_rd;
  logic [1:0]        bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              mem_rd;
  logic [RAM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              sig_valid;
  logic [31:0]       sig_data;
  logic              sig_last;
  logic              sig_ready;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  // {last, data}
  logic [32:0] exp_q[$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sig_dump_ctrl #(.RAM_AW(RAM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_last(sig_last),
    .sig_ready(sig_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- RAM model ----------------
  function automatic logic [31:0] mem_word(input logic [RAM_AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Data is valid exactly one cycle after mem_rd; garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_word(mem_addr);
    else        mem_rdata <= 32'hDEAD_BEEF;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void push_range(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] bb, ee;
    bb = b & 32'hFFFF_FFFC;
    ee = e & 32'hFFFF_FFFC;
    for (logic [31:0] p = bb; p < ee; p += 32'd4)
      exp_q.push_back({(p + 32'd4 >= ee), mem_word(p[RAM_AW+1:2])});
  endfunction

  // Stream monitor: samples on the falling edge, i.e. the values that the
  // next rising edge will act on.
  logic        stalled = 1'b0;
  logic [31:0] stall_data;
  logic [32:0] e;
  always @(negedge clk) begin
    if (!rst && sig_valid) begin
      if (stalled) check("stall_data_stable", sig_data, stall_data);
      if (sig_ready) begin
        hs_cnt++;
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sig_data", sig_data, e[31:0]);
          check("sig_last", 32'(sig_last), 32'(e[32]));
        end
        stalled = 1'b0;
      end else begin
        stalled    = 1'b1;
        stall_data = sig_data;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_wr = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_rd = 1'b1; bus_addr = a;
    @(posedge clk); #1;
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  // mode 0: sig_ready held high; mode 1: sig_ready cycles 1-0-0-1
  task automatic wait_done(input int mode, input int budget, output int cycles);
    cycles = budget;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (mode == 1) sig_ready = ((i % 4) == 0) || ((i % 4) == 3);
      else           sig_ready = 1'b1;
      if (done) begin cycles = i + 1; break; end
    end
    check("done_reached", 32'(done), 32'd1);
    sig_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  int          hs0;
  int          cyc;
  logic        saw_valid;

  initial begin
    rst = 1'b1; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = '0; bus_wdata = '0;
    sig_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sig_valid", 32'(sig_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_mem_rd",    32'(mem_rd),    32'd0);
    check("rst_sig_last",  32'(sig_last),  32'd0);
    check("rst_bus_rdata", bus_rdata,      32'd0);
    rst = 1'b0;
    bus_read(REG_BEGIN_A(), rd); check("rst_begin",  rd, 32'd0);
    bus_read(2'd3, rd);          check("rst_status", rd, 32'd0);

    // 1: four-word dump, sink always ready
    bus_write(2'd0, 32'h2000);
    bus_write(2'd1, 32'h2010);
    push_range(32'h2000, 32'h2010);
    hs0 = hs_cnt;
    bus_write(2'd2, 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(0, 200, cyc);
    check("t1_handshakes", 32'(hs_cnt - hs0), 32'd4);
    check("t1_cycles",     32'(cyc), 32'd13);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    bus_read(2'd3, rd); check("t1_status", rd, 32'h0004_0002);
    bus_read(2'd2, rd); check("t1_ctrl_reads_0", rd, 32'd0);

    // 2: same dump with backpressure
    push_range(32'h2000, 32'h2010);
    hs0 = hs_cnt;
    bus_write(2'd2, 32'h1);
    wait_done(1, 400, cyc);
    check("t2_handshakes", 32'(hs_cnt - hs0), 32'd4);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: empty range
    bus_write(2'd0, 32'h2010);
    hs0 = hs_cnt;
    saw_valid = 1'b0;
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | sig_valid;
      if (done) break;
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_no_valid", 32'(saw_valid), 32'd0);
    check("t3_handshakes", 32'(hs_cnt - hs0), 32'd0);
    bus_read(2'd3, rd); check("t3_status", rd, 32'h0000_0002);

    // 4: unaligned addresses
    bus_write(2'd0, 32'h2003);
    bus_write(2'd1, 32'h200B);
    bus_read(2'd0, rd); check("t4_begin_rb", rd, 32'h2000);
    bus_read(2'd1, rd); check("t4_end_rb",   rd, 32'h2008);
    push_range(32'h2000, 32'h2008);
    hs0 = hs_cnt;
    bus_write(2'd2, 32'h1);
    wait_done(0, 200, cyc);
    check("t4_handshakes", 32'(hs_cnt - hs0), 32'd2);
    bus_read(2'd3, rd); check("t4_status", rd, 32'h0002_0002);

    // 5: writes during a dump are ignored
    bus_write(2'd1, 32'h2010);
    push_range(32'h2000, 32'h2010);
    hs0 = hs_cnt;
    sig_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    bus_write(2'd0, 32'h4000);
    bus_write(2'd2, 32'h1);
    wait_done(0, 200, cyc);
    check("t5_handshakes", 32'(hs_cnt - hs0), 32'd4);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    bus_read(2'd0, rd); check("t5_begin_kept", rd, 32'h2000);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_restart", 32'(done), 32'd1);

    // 6: reset during SEND of word 2
    push_range(32'h2000, 32'h2010);
    hs0 = hs_cnt;
    sig_ready = 1'b1;
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (hs_cnt - hs0 >= 1) begin sig_ready = 1'b0; break; end
    end
    for (int i = 0; i < 10; i++) begin
      if (sig_valid) break;
      @(posedge clk); #1;
    end
    check("t6_in_send_w2", 32'(sig_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_valid_drop", 32'(sig_valid), 32'd0);
    check("t6_busy_drop",  32'(busy),      32'd0);
    check("t6_done_clr",   32'(done),      32'd0);
    check("t6_mem_rd",     32'(mem_rd),    32'd0);
    check("t6_last",       32'(sig_last),  32'd0);
    rst = 1'b0;
    exp_q.delete();
    bus_read(2'd0, rd); check("t6_begin_rst", rd, 32'd0);
    bus_write(2'd0, 32'h2000);
    bus_write(2'd1, 32'h2010);
    push_range(32'h2000, 32'h2010);
    hs0 = hs_cnt;
    bus_write(2'd2, 32'h1);
    wait_done(0, 200, cyc);
    check("t6_handshakes", 32'(hs_cnt - hs0), 32'd4);
    bus_read(2'd3, rd); check("t6_status", rd, 32'h0004_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [1:0] REG_BEGIN_A();
    return 2'd0;
  endfunction

endmodule
